// File: rtl/fetch_ctrl_pkg.sv
// Shared types and default sizes for the instruction-fetch sequencer.
package fetch_ctrl_pkg;

    localparam int FETCH_ADDR_W = 32;
    localparam int FETCH_INST_W = 32;
    localparam int FETCH_NBYTES = 4;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Byte-wide memory read port between the fetch sequencer (master) and memory (slave).
interface fetch_ctrl_if #(
    parameter int ADDR_W = fetch_ctrl_pkg::FETCH_ADDR_W
);
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_grant_i;
    logic [7:0]        mem_data_i;

    modport master (output mem_req_o, output mem_addr_o, input mem_grant_i, input mem_data_i);
    modport slave  (input mem_req_o, input mem_addr_o, output mem_grant_i, output mem_data_i);
endinterface

// File: rtl/fetch_ctrl_out_slot.sv
// One-entry output register towards IF/ID: flush beats load, load beats drain.
module fetch_ctrl_out_slot #(
    parameter int ADDR_W = fetch_ctrl_pkg::FETCH_ADDR_W,
    parameter int INST_W = fetch_ctrl_pkg::FETCH_INST_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_i,
    input  logic              flush_i,
    input  logic              drain_i,
    input  logic [INST_W-1:0] data_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              valid_o,
    output logic [INST_W-1:0] data_o,
    output logic [ADDR_W-1:0] pc_o
);
    logic              valid_q, valid_d;
    logic [INST_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] pc_q, pc_d;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        valid_d = valid_q;
        data_d  = data_q;
        pc_d    = pc_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            pc_d    = pc_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign pc_o    = pc_q;
endmodule

// File: rtl/fetch_ctrl.sv
// Fetches a little-endian instruction as serial byte reads at the current PC and
// hands it to IF/ID, stalling the PC register until the word is accepted.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int INST_W = FETCH_INST_W,
    parameter int NBYTES = FETCH_NBYTES
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_cur_i,
    input  logic              br,
    input  logic              stall_id,
    fetch_ctrl_if.master      mem,
    output logic              stall_pc_o,
    output logic              inst_valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o
);
    localparam int CNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

    fetch_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [INST_W-1:0] buf_q, buf_d;
    logic [INST_W-1:0] asm_word;
    logic              complete;
    logic              load;

    // The last byte bypasses the buffer so the word can load in its completing cycle.
    always_comb begin
        asm_word = buf_q;
        if (state_q == FETCH_RUN) asm_word[INST_W-8 +: 8] = mem.mem_data_i;
    end

    assign complete       = (state_q == FETCH_RUN) && mem.mem_grant_i && (cnt_q == LAST_BYTE);
    assign load           = (complete || (state_q == FETCH_HOLD)) && (!inst_valid_o || !stall_id) && !br;
    assign stall_pc_o     = !load;
    assign mem.mem_req_o  = (state_q == FETCH_RUN) && !br;
    assign mem.mem_addr_o = pc_cur_i + ADDR_W'(cnt_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        if (br) begin
            state_d = FETCH_RUN;
            cnt_d   = '0;
        end else begin
            case (state_q)
                FETCH_IDLE: state_d = FETCH_RUN;
                FETCH_RUN: begin
                    if (mem.mem_grant_i) begin
                        buf_d[{cnt_q, 3'b000} +: 8] = mem.mem_data_i;
                        if (cnt_q == LAST_BYTE) begin
                            cnt_d   = '0;
                            state_d = load ? FETCH_RUN : FETCH_HOLD;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                FETCH_HOLD: if (load) state_d = FETCH_RUN;
                default:    state_d = FETCH_IDLE;
            endcase
        end
    end

    // NOTE: the assembly buffer is reset too; it is only one word, and a defined value keeps X out of inst_o.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= FETCH_IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

    fetch_ctrl_out_slot #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W)
    ) u_slot (
        .clock   (clock),
        .reset   (reset),
        .load_i  (load),
        .flush_i (br),
        .drain_i (!stall_id),
        .data_i  (asm_word),
        .pc_i    (pc_cur_i),
        .valid_o (inst_valid_o),
        .data_o  (inst_o),
        .pc_o    (inst_pc_o)
    );
endmodule
